lsu_controller: RTL and testbench

LSU_CONTROLLER -- requirements
Module: lsu_controller

---
 rtl/lsu_controller_if.sv | 21 ++
 rtl/lsu_controller.sv | 164 ++++++++++++++++
 tb/tb_lsu_controller.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_controller_if.sv
// Bus side of the load/store unit: one outstanding request, completed by a
// single-cycle BusAck that also qualifies BusRData.
interface lsu_controller_if;
   logic        BusReq;
   logic        BusWrite;
   logic [31:0] BusAddr;
   logic [31:0] BusWData;
   logic [3:0]  BusByteEn;
   logic        BusAck;
   logic [31:0] BusRData;

   modport master (
      output BusReq, BusWrite, BusAddr, BusWData, BusByteEn,
      input  BusAck, BusRData
   );

   modport slave (
      input  BusReq, BusWrite, BusAddr, BusWData, BusByteEn,
      output BusAck, BusRData
   );
endinterface

// File: rtl/lsu_controller.sv
// Load/store controller: latches a decoded memory op, runs one bus access with
// a wait timeout, and returns the aligned/extended load result for writeback.
module lsu_controller #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  Start,
   input  logic [3:0]            CtrlLSU,
   input  logic [31:0]           Addr,
   input  logic [31:0]           StoreData,
   input  logic [4:0]            RdIn,
   lsu_controller_if.master      bus,
   output logic                  Stall,
   output logic                  WbEnable,
   output logic [4:0]            WbAddr,
   output logic [31:0]           WbData,
   output logic                  Fault,
   output logic                  Busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUS   = 2'd1,
      WB    = 2'd2,
      FAULT = 2'd3
   } state_t;

   localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [3:0]  ctrl_q, ctrl_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [4:0]  rd_q, rd_d;
   logic [31:0] wb_data_q, wb_data_d;

   logic        misaligned;
   logic [31:0] shifted;
   logic [31:0] load_data;
   logic        in_bus;
   logic        done;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         ctrl_q    <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rd_q      <= '0;
         wb_data_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         ctrl_q    <= ctrl_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         rd_q      <= rd_d;
         wb_data_q <= wb_data_d;
      end
   end

   // Load result: move the addressed lane down to bit 0, then trim and extend.
   always_comb begin
      shifted   = bus.BusRData >> {addr_q[1:0], 3'b000};
      load_data = shifted;
      case (ctrl_q[1:0])
         2'b10:   load_data = ctrl_q[3] ? {16'h0000, shifted[15:0]}
                                        : {{16{shifted[15]}}, shifted[15:0]};
         2'b11:   load_data = ctrl_q[3] ? {24'h000000, shifted[7:0]}
                                        : {{24{shifted[7]}}, shifted[7:0]};
         default: load_data = shifted;
      endcase
   end

   always_comb begin
      misaligned = ((CtrlLSU[1:0] == 2'b01) && (Addr[1:0] != 2'b00)) ||
                   ((CtrlLSU[1:0] == 2'b10) && Addr[0]);

      state_d   = state_q;
      cnt_d     = cnt_q;
      ctrl_d    = ctrl_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rd_d      = rd_q;
      wb_data_d = wb_data_q;

      case (state_q)
         IDLE: begin
            if (Start && (CtrlLSU[1:0] != 2'b00)) begin
               ctrl_d  = CtrlLSU;
               addr_d  = Addr;
               wdata_d = StoreData;
               rd_d    = RdIn;
               cnt_d   = '0;
               state_d = misaligned ? FAULT : BUS;
            end
         end
         BUS: begin
            // An ack arriving on the final wait cycle still completes normally.
            if (bus.BusAck) begin
               if (ctrl_q[2]) begin
                  state_d = IDLE;
               end else begin
                  wb_data_d = load_data;
                  state_d   = WB;
               end
            end else begin
               cnt_d = cnt_q + 8'd1;
               if (cnt_q == TimeoutLast) begin
                  state_d = FAULT;
               end
            end
         end
         WB:      state_d = IDLE;
         FAULT:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Bus outputs are only driven while the access is outstanding.
   always_comb begin
      in_bus        = (state_q == BUS);
      bus.BusReq    = in_bus;
      bus.BusWrite  = in_bus & ctrl_q[2];
      bus.BusAddr   = in_bus ? {addr_q[31:2], 2'b00} : 32'h0;
      bus.BusWData  = 32'h0;
      bus.BusByteEn = 4'b0000;
      if (in_bus) begin
         case (ctrl_q[1:0])
            2'b01: begin
               bus.BusWData  = wdata_q;
               bus.BusByteEn = 4'b1111;
            end
            2'b10: begin
               bus.BusWData  = {2{wdata_q[15:0]}};
               bus.BusByteEn = 4'b0011 << addr_q[1:0];
            end
            2'b11: begin
               bus.BusWData  = {4{wdata_q[7:0]}};
               bus.BusByteEn = 4'b0001 << addr_q[1:0];
            end
            default: begin
               bus.BusWData  = 32'h0;
               bus.BusByteEn = 4'b0000;
            end
         endcase
      end
   end

   always_comb begin
      done     = (in_bus && bus.BusAck && ctrl_q[2]) ||
                 (state_q == WB) || (state_q == FAULT);
      Stall    = Start && (CtrlLSU[1:0] != 2'b00) && !done;
      WbEnable = (state_q == WB);
      WbAddr   = (state_q == WB) ? rd_q : 5'd0;
      WbData   = (state_q == WB) ? wb_data_q : 32'h0;
      Fault    = (state_q == FAULT);
      Busy     = (state_q != IDLE);
   end

endmodule

// File: tb/tb_lsu_controller.sv
// Directed bench for lsu_controller: each op expands into a per-cycle expected
// output trace that a single negedge process compares against the DUT.
module tb_lsu_controller;

   localparam int TO = 4;

   typedef struct packed {
      logic        req;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic        stall;
      logic        wben;
      logic [4:0]  wbaddr;
      logic [31:0] wbdata;
      logic        fault;
      logic        busy;
   } out_t;

   logic        clk;
   logic        rst;
   logic        Start;
   logic [3:0]  CtrlLSU;
   logic [31:0] Addr;
   logic [31:0] StoreData;
   logic [4:0]  RdIn;
   logic        Stall;
   logic        WbEnable;
   logic [4:0]  WbAddr;
   logic [31:0] WbData;
   logic        Fault;
   logic        Busy;

   lsu_controller_if bus_if ();

   lsu_controller #(.TIMEOUT(TO)) dut (
      .clk       (clk),
      .rst       (rst),
      .Start     (Start),
      .CtrlLSU   (CtrlLSU),
      .Addr      (Addr),
      .StoreData (StoreData),
      .RdIn      (RdIn),
      .bus       (bus_if),
      .Stall     (Stall),
      .WbEnable  (WbEnable),
      .WbAddr    (WbAddr),
      .WbData    (WbData),
      .Fault     (Fault),
      .Busy      (Busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   out_t        exp_q[$];
   string       cur_op;
   int          check_count = 0;
   int          pass_count  = 0;
   int          stall_cnt, req_cnt, wben_cnt, fault_cnt;
   logic [31:0] last_addr, last_wdata, last_wb;
   logic [3:0]  last_be;

   function automatic out_t actual_outputs();
      out_t a;
      a.req    = bus_if.BusReq;
      a.wr     = bus_if.BusWrite;
      a.addr   = bus_if.BusAddr;
      a.wdata  = bus_if.BusWData;
      a.be     = bus_if.BusByteEn;
      a.stall  = Stall;
      a.wben   = WbEnable;
      a.wbaddr = WbAddr;
      a.wbdata = WbData;
      a.fault  = Fault;
      a.busy   = Busy;
      return a;
   endfunction

   // Per-cycle comparison plus event tallies used by the literal checks.
   always @(negedge clk) begin
      out_t e, a;
      a = actual_outputs();
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check_count++;
         if (a === e) pass_count++;
         else $display("[TB] FAIL trace %s: got %h expected %h", cur_op, a, e);
      end
      if (Stall) stall_cnt++;
      if (Fault) fault_cnt++;
      if (bus_if.BusReq) begin
         req_cnt++;
         last_addr  = bus_if.BusAddr;
         last_wdata = bus_if.BusWData;
         last_be    = bus_if.BusByteEn;
      end
      if (WbEnable) begin
         wben_cnt++;
         last_wb = WbData;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      check_count++;
      if (act === exp) pass_count++;
      else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic logic [31:0] model_load(input logic [31:0] rdata, input logic [31:0] a,
                                              input logic [3:0] ctrl);
      logic [31:0] v;
      v = rdata >> (8 * (a % 4));
      if (ctrl[1:0] == 2'b10) begin
         v = v % 32'h10000;
         if (!ctrl[3] && v >= 32'h8000) v = v + 32'hFFFF0000;
      end else if (ctrl[1:0] == 2'b11) begin
         v = v % 32'h100;
         if (!ctrl[3] && v >= 32'h80) v = v + 32'hFFFFFF00;
      end
      return v;
   endfunction

   task automatic idle(input int n);
      out_t e;
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         Start   = 1'b0;
         bus_if.BusAck = 1'b0;
         e = '0;
         exp_q.push_back(e);
      end
   endtask

   // ack_wait: number of bus cycles without ack before the ack (-1 = never).
   task automatic applyStimulus(input string name, input logic [3:0] ctrl, input logic [31:0] a,
                                input logic [31:0] sd, input logic [4:0] rd,
                                input int ack_wait, input logic [31:0] rdata);
      out_t e;
      bit   st, mis, acked;
      int   lane;
      st   = ctrl[2];
      lane = int'(a % 4);
      mis  = (ctrl[1:0] == 2'b01 && lane != 0) || (ctrl[1:0] == 2'b10 && (lane % 2) != 0);
      cur_op = name;
      stall_cnt = 0; req_cnt = 0; wben_cnt = 0; fault_cnt = 0;
      last_addr = '0; last_wdata = '0; last_be = '0; last_wb = '0;

      @(posedge clk); #1;
      Start = 1'b1; CtrlLSU = ctrl; Addr = a; StoreData = sd; RdIn = rd;
      bus_if.BusAck = 1'b0; bus_if.BusRData = 32'h0;
      e = '0; e.stall = 1'b1;
      exp_q.push_back(e);

      acked = 1'b0;
      if (!mis) begin
         for (int i = 0; i < TO && !acked; i++) begin
            @(posedge clk); #1;
            Addr = ~a; StoreData = ~sd; RdIn = ~rd;
            acked = (i == ack_wait);
            bus_if.BusAck   = acked;
            bus_if.BusRData = acked ? rdata : 32'hDEAD_BEEF;
            e = '0;
            e.req   = 1'b1;
            e.wr    = st;
            e.addr  = a - (a % 4);
            e.busy  = 1'b1;
            e.stall = !(acked && st);
            case (ctrl[1:0])
               2'b01: begin e.wdata = sd;                   e.be = 4'hF; end
               2'b10: begin e.wdata = {sd[15:0], sd[15:0]}; e.be = 4'(3 << lane); end
               default: begin e.wdata = {4{sd[7:0]}};       e.be = 4'(1 << lane); end
            endcase
            exp_q.push_back(e);
         end
      end

      if (acked && st) return;
      @(posedge clk); #1;
      bus_if.BusAck = 1'b0;
      e = '0;
      e.busy = 1'b1;
      if (acked) begin
         e.wben   = 1'b1;
         e.wbaddr = rd;
         e.wbdata = model_load(rdata, a, ctrl);
      end else begin
         e.fault = 1'b1;
      end
      exp_q.push_back(e);
   endtask

   task automatic checkOutput(input string name);
      out_t a;
      a = actual_outputs();
      check({name, " outputs zero"}, {31'h0, (a != '0)}, 32'h0);
   endtask

   initial begin
      out_t e;
      rst = 1'b0; Start = 1'b0; CtrlLSU = '0; Addr = '0; StoreData = '0; RdIn = '0;
      bus_if.BusAck = 1'b0; bus_if.BusRData = '0;
      repeat (2) @(negedge clk);
      checkOutput("reset state");
      check("reset BusByteEn", {28'h0, bus_if.BusByteEn}, 32'h0);
      @(posedge clk); #3; rst = 1'b1;

      idle(1);
      check("model byte signed pin", model_load(32'h80AABBCC, 32'h103, 4'b0011), 32'hFFFFFF80);
      check("model half unsigned pin", model_load(32'h8001FFFF, 32'h2, 4'b1010), 32'h00008001);

      applyStimulus("lb 0x103", 4'b0011, 32'h103, 32'h0, 5'd7, 2, 32'h80AABBCC);
      idle(1);
      check("lb stall cycles", stall_cnt, 4);
      check("lb BusByteEn", {28'h0, last_be}, 32'h8);
      check("lb WbData", last_wb, 32'hFFFFFF80);
      check("lb WbEnable pulses", wben_cnt, 1);

      applyStimulus("sh 0x202", 4'b0110, 32'h202, 32'h1234ABCD, 5'd3, 1, 32'h0);
      idle(1);
      check("sh BusAddr", last_addr, 32'h200);
      check("sh BusByteEn", {28'h0, last_be}, 32'hC);
      check("sh BusWData", last_wdata, 32'hABCDABCD);
      check("sh WbEnable pulses", wben_cnt, 0);
      check("sh stall cycles", stall_cnt, 2);

      applyStimulus("lw 0x101 misaligned", 4'b0001, 32'h101, 32'h0, 5'd4, 0, 32'h0);
      idle(1);
      check("lw mis BusReq cycles", req_cnt, 0);
      check("lw mis Fault pulses", fault_cnt, 1);
      check("lw mis stall cycles", stall_cnt, 1);

      applyStimulus("lw timeout", 4'b0001, 32'h400, 32'h0, 5'd5, -1, 32'h0);
      idle(1);
      check("timeout BusReq cycles", req_cnt, TO);
      check("timeout Fault pulses", fault_cnt, 1);
      check("timeout WbEnable pulses", wben_cnt, 0);

      applyStimulus("sw ack on last cycle", 4'b0101, 32'h404, 32'hCAFEF00D, 5'd0, TO - 1, 32'h0);
      idle(1);
      check("late ack BusReq cycles", req_cnt, TO);
      check("late ack Fault pulses", fault_cnt, 0);

      applyStimulus("lhu 0x2", 4'b1010, 32'h2, 32'h0, 5'd9, 0, 32'h8001FFFF);
      idle(1);
      check("lhu WbData", last_wb, 32'h00008001);

      applyStimulus("lbu 0x1", 4'b1011, 32'h1, 32'h0, 5'd10, 1, 32'h11228344);
      applyStimulus("lb 0x1", 4'b0011, 32'h1, 32'h0, 5'd11, 0, 32'h11228344);
      applyStimulus("lh 0x6", 4'b0010, 32'h6, 32'h0, 5'd12, 2, 32'h9ABC0000);
      applyStimulus("sb 0x7", 4'b0111, 32'h7, 32'h000000A5, 5'd1, 0, 32'h0);
      applyStimulus("lw x0", 4'b0001, 32'h8, 32'h0, 5'd0, 0, 32'h5555AAAA);
      idle(1);
      check("lw x0 WbEnable pulses", wben_cnt, 1);
      applyStimulus("lh 0x3 misaligned", 4'b0010, 32'h3, 32'h0, 5'd2, 0, 32'h0);

      // Width 00 is not a memory op; a stray ack in IDLE must do nothing.
      @(posedge clk); #1;
      cur_op = "nop width"; Start = 1'b1; CtrlLSU = 4'b0100; Addr = 32'h10;
      bus_if.BusAck = 1'b1; bus_if.BusRData = 32'h12345678;
      e = '0; exp_q.push_back(e);
      idle(2);

      applyStimulus("reset mid-bus", 4'b0001, 32'h300, 32'h0, 5'd6, -1, 32'h0);
      @(posedge clk); #1;
      exp_q.delete();
      rst = 1'b0; Start = 1'b0;
      #1;
      check("mid-reset BusReq", {31'h0, bus_if.BusReq}, 32'h0);
      check("mid-reset Busy", {31'h0, Busy}, 32'h0);
      checkOutput("mid-reset");
      wben_cnt = 0;
      @(posedge clk); #1;
      rst = 1'b1;
      bus_if.BusAck = 1'b1; bus_if.BusRData = 32'h77777777;
      e = '0; exp_q.push_back(e);
      idle(3);
      check("post-reset WbEnable pulses", wben_cnt, 0);

      applyStimulus("b2b sw", 4'b0101, 32'h500, 32'h01020304, 5'd1, 0, 32'h0);
      applyStimulus("b2b lw", 4'b0001, 32'h504, 32'h0, 5'd2, 0, 32'hFEDCBA98);
      applyStimulus("b2b lbu", 4'b1011, 32'h506, 32'h0, 5'd3, 1, 32'hFEDCBA98);
      idle(3);

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
